// File: rtl/pal576i_sync_generator.sv
// rtl/pal576i_sync_generator.sv - PAL 576i (625-line, 2:1 interlace) sync and active-area timing generator
//
// Free-running transmit timing source, advanced by a one-cycle pixel tick.
//   sysClk        in   system clock
//   reset         in   asynchronous active-high reset
//   pixelTick     in   one-cycle pulse per pixel period; state advances only when high
//   csync         out  composite sync (broad / equalising / line pulses), active-low
//   hsync         out  line sync, active-low, on every line
//   vsync         out  vertical sync, active-low through the broad half-lines
//   isFieldOdd    out  1 = field 1, 0 = field 2
//   pixelX        out  active column, 0 outside the active area
//   pixelY        out  interleaved frame row 0..575, 0 outside the active area
//   displayEnable out  high inside the active area
//   startOfFrame  out  high for the first active pixel of the frame
module pal576i_sync_generator #(
    parameter int H_TOTAL        = 864,
    parameter int H_SYNC         = 64,
    parameter int H_EQ           = 32,
    parameter int H_BROAD        = 368,
    parameter int H_ACTIVE_START = 132,
    parameter int H_ACTIVE       = 720
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       pixelTick,
    output logic       csync,
    output logic       hsync,
    output logic       vsync,
    output logic       isFieldOdd,
    output logic [9:0] pixelX,
    output logic [9:0] pixelY,
    output logic       displayEnable,
    output logic       startOfFrame
);

    localparam logic [9:0] HC_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HC_HALF   = 10'(H_TOTAL / 2);
    localparam logic [9:0] HC_SYNC   = 10'(H_SYNC);
    localparam logic [9:0] HC_EQ     = 10'(H_EQ);
    localparam logic [9:0] HC_BROAD  = 10'(H_BROAD);
    localparam logic [9:0] HC_ACT_LO = 10'(H_ACTIVE_START);
    localparam logic [9:0] HC_ACT_HI = 10'(H_ACTIVE_START + H_ACTIVE);

    logic [9:0]  h_count_q, h_count_d;
    logic [9:0]  line_q, line_d;
    logic        csync_q, csync_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        field_odd_q, field_odd_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        de_q, de_d;
    logic        sof_q, sof_d;

    logic        second_half;
    logic [9:0]  h_half;
    logic [10:0] half_idx;
    logic        is_broad, is_eq, is_line_pulse;
    logic        field1_rows, field2_rows, active;

    // Every output is derived from the next counter state so it lines up with
    // the counters with no extra latency.
    always_comb begin
        h_count_d = h_count_q;
        line_d    = line_q;
        if (h_count_q == HC_LAST) begin
            h_count_d = 10'd0;
            line_d    = (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
        end else begin
            h_count_d = h_count_q + 10'd1;
        end

        second_half = (h_count_d >= HC_HALF);
        h_half      = second_half ? h_count_d - HC_HALF : h_count_d;
        // Half-line index 2*(line-1) + second_half, built by concatenation.
        half_idx    = {line_d - 10'd1, second_half};

        // Vertical interval layout is fixed by the 625-line standard.
        is_broad = (half_idx <= 11'd4) ||
                   (half_idx >= 11'd625 && half_idx <= 11'd629);
        is_eq    = (half_idx >= 11'd1245) ||
                   (half_idx >= 11'd5   && half_idx <= 11'd9)   ||
                   (half_idx >= 11'd620 && half_idx <= 11'd624) ||
                   (half_idx >= 11'd630 && half_idx <= 11'd634);
        is_line_pulse = !is_broad && !is_eq && !second_half;

        csync_d = !((is_broad      && h_half < HC_BROAD) ||
                    (is_eq         && h_half < HC_EQ)    ||
                    (is_line_pulse && h_half < HC_SYNC));
        hsync_d     = !(h_count_d < HC_SYNC);
        vsync_d     = !is_broad;
        field_odd_d = (half_idx <= 11'd624);

        field1_rows = (line_d >= 10'd23)  && (line_d <= 10'd310);
        field2_rows = (line_d >= 10'd336) && (line_d <= 10'd623);
        active      = (h_count_d >= HC_ACT_LO) && (h_count_d < HC_ACT_HI) &&
                      (field1_rows || field2_rows);

        pixel_x_d = 10'd0;
        pixel_y_d = 10'd0;
        if (active) begin
            pixel_x_d = h_count_d - HC_ACT_LO;
            // Field 1 fills even frame rows, field 2 the odd ones.
            pixel_y_d = field1_rows ? ((line_d - 10'd23) << 1)
                                    : (((line_d - 10'd336) << 1) | 10'd1);
        end
        de_d  = active;
        sof_d = active && (pixel_x_d == 10'd0) && (pixel_y_d == 10'd0);
    end

    // Reset parks the counters on the last tick of line 625 so the first tick
    // lands on line 1, hCount 0.
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            h_count_q   <= HC_LAST;
            line_q      <= 10'd625;
            csync_q     <= 1'b1;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            field_odd_q <= 1'b1;
            pixel_x_q   <= 10'd0;
            pixel_y_q   <= 10'd0;
            de_q        <= 1'b0;
            sof_q       <= 1'b0;
        end else if (pixelTick) begin
            h_count_q   <= h_count_d;
            line_q      <= line_d;
            csync_q     <= csync_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            field_odd_q <= field_odd_d;
            pixel_x_q   <= pixel_x_d;
            pixel_y_q   <= pixel_y_d;
            de_q        <= de_d;
            sof_q       <= sof_d;
        end
    end

    assign csync         = csync_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign isFieldOdd    = field_odd_q;
    assign pixelX        = pixel_x_q;
    assign pixelY        = pixel_y_q;
    assign displayEnable = de_q;
    assign startOfFrame  = sof_q;

endmodule

// File: tb/tb_pal576i_sync_generator.sv
// tb/tb_pal576i_sync_generator.sv - scoreboard bench for pal576i_sync_generator
module tb_pal576i_sync_generator;

    // Shortened line so whole frames fit in a short run; every timing rule
    // is expressed in terms of these values.
    localparam int HT    = 64;
    localparam int HS    = 6;
    localparam int HE    = 3;
    localparam int HB    = HT / 2 - HS;
    localparam int HAS   = 10;
    localparam int HA    = 50;
    localparam int FRAME = 625 * HT;

    typedef struct packed {
        logic       cs;
        logic       hs;
        logic       vs;
        logic       odd;
        logic [9:0] px;
        logic [9:0] py;
        logic       de;
        logic       sof;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixelTick;
    logic       csync, hsync, vsync, isFieldOdd, displayEnable, startOfFrame;
    logic [9:0] pixelX, pixelY;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];
    longint ticks = 0;   // ticks since reset release (model time base)

    pal576i_sync_generator #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_EQ(HE), .H_BROAD(HB),
        .H_ACTIVE_START(HAS), .H_ACTIVE(HA)
    ) dut (
        .sysClk(clk), .reset(reset), .pixelTick(pixelTick),
        .csync(csync), .hsync(hsync), .vsync(vsync), .isFieldOdd(isFieldOdd),
        .pixelX(pixelX), .pixelY(pixelY), .displayEnable(displayEnable),
        .startOfFrame(startOfFrame)
    );

    always #5 clk = ~clk;

    // Reference: position in the frame taken straight from elapsed tick count.
    function automatic exp_t model(input longint t);
        exp_t e;
        int p, hc, ln, hi, hh;
        bit broad, eq, linep, act;
        e = '{cs:1'b1, hs:1'b1, vs:1'b1, odd:1'b1, px:10'd0, py:10'd0, de:1'b0, sof:1'b0};
        if (t == 0) return e;
        p  = int'((t - 1) % FRAME);
        hc = p % HT;
        ln = p / HT + 1;
        hi = 2 * (ln - 1) + ((hc >= HT / 2) ? 1 : 0);
        hh = hc % (HT / 2);
        broad = (hi <= 4) || (hi >= 625 && hi <= 629);
        eq    = (hi >= 1245) || (hi >= 5 && hi <= 9) ||
                (hi >= 620 && hi <= 624) || (hi >= 630 && hi <= 634);
        linep = !broad && !eq && (hc < HT / 2);
        e.cs  = !((broad && hh < HB) || (eq && hh < HE) || (linep && hh < HS));
        e.hs  = !(hc < HS);
        e.vs  = !broad;
        e.odd = (hi <= 624);
        act   = (hc >= HAS) && (hc < HAS + HA) &&
                ((ln >= 23 && ln <= 310) || (ln >= 336 && ln <= 623));
        if (act) begin
            e.de = 1'b1;
            e.px = 10'(hc - HAS);
            e.py = (ln <= 310) ? 10'(2 * (ln - 23)) : 10'(2 * (ln - 336) + 1);
            e.sof = (e.px == 10'd0) && (e.py == 10'd0);
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{cs:csync, hs:hsync, vs:vsync, odd:isFieldOdd, px:pixelX, py:pixelY,
              de:displayEnable, sof:startOfFrame};
        return o;
    endfunction

    task automatic compare(input string name, input exp_t got, input exp_t want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s t=%0t ticks=%0d got cs=%b hs=%b vs=%b odd=%b x=%0d y=%0d de=%b sof=%b want cs=%b hs=%b vs=%b odd=%b x=%0d y=%0d de=%b sof=%b",
                     name, $time, ticks, got.cs, got.hs, got.vs, got.odd, got.px, got.py, got.de, got.sof,
                     want.cs, want.hs, want.vs, want.odd, want.px, want.py, want.de, want.sof);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint want);
        n_compared++;
        if (got != want) begin
            n_mismatched++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // One cycle of stimulus; the expectation for the state after the next
    // rising edge goes onto the scoreboard.
    task automatic step(input bit t, input bit r);
        @(negedge clk);
        pixelTick = t;
        reset     = r;
        if (r) ticks = 0;
        else if (t) ticks++;
        exp_q.push_back(model(ticks));
    endtask

    // Frame-level statistics gathered from DUT outputs alone.
    longint tick_idx = 0, last_sof = 0, de_ticks = 0, de_lines = 0;
    int     sof_cnt  = 0;
    bit     de_prev  = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) compare("scoreboard", observed(), exp_q.pop_front());
        if (reset) begin
            tick_idx = 0; sof_cnt = 0; de_ticks = 0; de_lines = 0; de_prev = 1'b0;
        end else if (pixelTick) begin
            tick_idx++;
            if (startOfFrame) begin
                if (sof_cnt > 0) begin
                    check_int("sof_period", tick_idx - last_sof, FRAME);
                    check_int("de_ticks_per_frame", de_ticks, 576 * HA);
                    check_int("de_lines_per_frame", de_lines, 576);
                end
                sof_cnt++;
                last_sof = tick_idx;
                de_ticks = 0;
                de_lines = 0;
            end
            if (displayEnable) begin
                de_ticks++;
                if (!de_prev) de_lines++;
            end
            de_prev = displayEnable;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        pixelTick = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);

        // Release with ticks running at random density.
        while (ticks < 2500) step($urandom_range(0, 3) != 0, 1'b0);

        // Hold mid-line: scoreboard expects everything frozen.
        repeat (100) step(1'b0, 1'b0);
        repeat (37) step(1'b1, 1'b0);

        // Asynchronous reset mid-line, checked before any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset", observed(), model(0));
        ticks = 0;
        exp_q.push_back(model(0));
        repeat (4) step($urandom_range(0, 1) != 0, 1'b1);

        // Over one full frame so two start-of-frame pulses are seen.
        while (ticks < FRAME + 1600) step($urandom_range(0, 9) != 0, 1'b0);

        @(posedge clk);
        #3;
        check_int("scoreboard_drained", exp_q.size(), 0);
        check_int("sof_seen", sof_cnt, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
